// File: rtl/gray_threshold_blob_if.sv
// rtl/gray_threshold_blob_if.sv - pixel stream bundle between camera pipeline stages
// Signals:
//   valid  - pixel strobe
//   data   - 10-bit pixel value (gray in, binarised out)
//   visual - pixel lies in the visible area
//   done   - frame-done level
// Modports: master drives the stream, slave receives it.
interface gray_threshold_blob_if;
    logic       valid;
    logic [9:0] data;
    logic       visual;
    logic       done;

    modport master (output valid, output data, output visual, output done);
    modport slave  (input  valid, input  data, input  visual, input  done);
endinterface

// File: rtl/gray_threshold_blob.sv
// rtl/gray_threshold_blob.sv - gray binarisation with per-frame blob statistics
// Ports:
//   clock, reset_n     - clock, synchronous active-low reset
//   in_px (slave)      - gray pixel stream from the gray-conversion stage
//   out_px (master)    - binarised stream, one cycle behind in_px
//   threshold          - binarisation threshold, sampled once per frame
//   result_valid       - one-cycle pulse when result_* are updated
//   result_count       - foreground pixels in the last frame
//   result_sum_x/y     - sums of foreground coordinates (centroid numerators)
//   result_min/max_x/y - bounding box, all zero for an empty frame
//   result_empty       - last frame had no foreground pixels
module gray_threshold_blob #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                   clock,
    input  logic                   reset_n,
    gray_threshold_blob_if.slave   in_px,
    gray_threshold_blob_if.master  out_px,
    input  logic [9:0]             threshold,
    output logic                   result_valid,
    output logic [19:0]            result_count,
    output logic [29:0]            result_sum_x,
    output logic [29:0]            result_sum_y,
    output logic [11:0]            result_min_x,
    output logic [11:0]            result_max_x,
    output logic [11:0]            result_min_y,
    output logic [11:0]            result_max_y,
    output logic                   result_empty
);

    typedef enum logic [1:0] {
        ACCUM     = 2'd0,
        LATCH     = 2'd1,
        DONE_WAIT = 2'd2
    } state_t;

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

    state_t      state_q, state_d;
    logic [9:0]  thr_q;
    logic        done_q;
    logic [11:0] x_q, y_q;
    logic [19:0] count_q;
    logic [29:0] sum_x_q, sum_y_q;
    logic [11:0] min_x_q, max_x_q, min_y_q, max_y_q;

    logic fg, pix, done_rise;

    assign fg        = (in_px.data >= thr_q);
    assign pix       = in_px.valid & in_px.visual;
    assign done_rise = in_px.done & ~done_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:     if (done_rise) state_d = LATCH;
            LATCH:     state_d = DONE_WAIT;
            DONE_WAIT: if (!in_px.done) state_d = ACCUM;
            default:   state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            thr_q         <= threshold;
            done_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            count_q       <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            min_x_q       <= '1;
            max_x_q       <= '0;
            min_y_q       <= '1;
            max_y_q       <= '0;
            out_px.valid  <= 1'b0;
            out_px.data   <= '0;
            out_px.visual <= 1'b0;
            out_px.done   <= 1'b0;
            result_valid  <= 1'b0;
            result_count  <= '0;
            result_sum_x  <= '0;
            result_sum_y  <= '0;
            result_min_x  <= '0;
            result_max_x  <= '0;
            result_min_y  <= '0;
            result_max_y  <= '0;
            result_empty  <= 1'b0;
        end else begin
            done_q        <= in_px.done;
            out_px.valid  <= in_px.valid;
            out_px.visual <= in_px.visual;
            out_px.done   <= in_px.done;
            out_px.data   <= fg ? 10'h3FF : 10'h000;
            result_valid  <= 1'b0;

            case (state_q)
                ACCUM: begin
                    // A pixel coinciding with the done edge belongs to no frame.
                    if (pix && !done_rise) begin
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= (y_q == Y_LAST) ? 12'd0 : y_q + 12'd1;
                        end else begin
                            x_q <= x_q + 12'd1;
                        end
                        if (fg) begin
                            count_q <= count_q + 20'd1;
                            sum_x_q <= sum_x_q + {18'd0, x_q};
                            sum_y_q <= sum_y_q + {18'd0, y_q};
                            if (x_q < min_x_q) min_x_q <= x_q;
                            if (x_q > max_x_q) max_x_q <= x_q;
                            if (y_q < min_y_q) min_y_q <= y_q;
                            if (y_q > max_y_q) max_y_q <= y_q;
                        end
                    end
                end
                LATCH: begin
                    result_valid <= 1'b1;
                    result_count <= count_q;
                    result_sum_x <= sum_x_q;
                    result_sum_y <= sum_y_q;
                    result_empty <= (count_q == 20'd0);
                    // The min registers still hold 4095 on an empty frame; report a zero box.
                    if (count_q == 20'd0) begin
                        result_min_x <= '0;
                        result_max_x <= '0;
                        result_min_y <= '0;
                        result_max_y <= '0;
                    end else begin
                        result_min_x <= min_x_q;
                        result_max_x <= max_x_q;
                        result_min_y <= min_y_q;
                        result_max_y <= max_y_q;
                    end
                    count_q <= '0;
                    sum_x_q <= '0;
                    sum_y_q <= '0;
                    min_x_q <= '1;
                    max_x_q <= '0;
                    min_y_q <= '1;
                    max_y_q <= '0;
                    x_q     <= '0;
                    y_q     <= '0;
                end
                DONE_WAIT: begin
                    if (!in_px.done) thr_q <= threshold;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_threshold_blob.sv
// tb/tb_gray_threshold_blob.sv - directed self-checking bench for gray_threshold_blob
module tb_gray_threshold_blob;
    localparam int W = 8;
    localparam int H = 4;

    logic        clock;
    logic        reset_n;
    logic [9:0]  threshold;
    logic        result_valid;
    logic [19:0] result_count;
    logic [29:0] result_sum_x, result_sum_y;
    logic [11:0] result_min_x, result_max_x, result_min_y, result_max_y;
    logic        result_empty;

    gray_threshold_blob_if in_if ();
    gray_threshold_blob_if out_if ();

    gray_threshold_blob #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_px        (in_if),
        .out_px       (out_if),
        .threshold    (threshold),
        .result_valid (result_valid),
        .result_count (result_count),
        .result_sum_x (result_sum_x),
        .result_sum_y (result_sum_y),
        .result_min_x (result_min_x),
        .result_max_x (result_max_x),
        .result_min_y (result_min_y),
        .result_max_y (result_max_y),
        .result_empty (result_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    logic [9:0] thr_active;

    typedef struct {
        logic       v;
        logic [9:0] g;
        logic       vis;
        logic       d;
        logic [9:0] eb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [9:0] g, input logic vis, input logic d);
        @(negedge clock);
        in_if.valid  = v;
        in_if.data   = g;
        in_if.visual = vis;
        in_if.done   = d;
        @(posedge clock);
        #1;
        if (result_valid === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b1, 10'd600, 1'b1, 1'b1);
        reset_n = 1'b1;
        thr_active = threshold;
        pulses = 0;
    endtask

    // Pixels lo..hi of a raster frame; mask bit y*W+x marks gray=hi_gray, others gray=100.
    task automatic send_range(input logic [31:0] mask, input int lo, input int hi, input logic [9:0] hi_gray);
        logic [9:0] g;
        for (int i = lo; i <= hi; i++) begin
            g = mask[i] ? hi_gray : 10'd100;
            step(1'b1, g, 1'b1, 1'b0);
            chk("bin", 32'(out_if.data), (g >= thr_active) ? 32'h3FF : 32'h0);
        end
    endtask

    task automatic done_pulse(input int n_high, input logic pix_during);
        for (int i = 0; i < n_high; i++) step(pix_during, 10'd600, pix_during, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b0);
        step(1'b0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic check_res(input int c, input int sx, input int sy, input int x0, input int x1,
                             input int y0, input int y1, input logic e);
        chk("pulses", 32'(pulses), 32'd1);
        chk("count", 32'(result_count), 32'(c));
        chk("sum_x", 32'(result_sum_x), 32'(sx));
        chk("sum_y", 32'(result_sum_y), 32'(sy));
        chk("min_x", 32'(result_min_x), 32'(x0));
        chk("max_x", 32'(result_max_x), 32'(x1));
        chk("min_y", 32'(result_min_y), 32'(y0));
        chk("max_y", 32'(result_max_y), 32'(y1));
        chk("empty", 32'(result_empty), 32'(e));
        pulses = 0;
    endtask

    initial begin
        reset_n      = 1'b0;
        threshold    = 10'd512;
        thr_active   = 10'd512;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.visual = 1'b0;
        in_if.done   = 1'b0;

        vecs[0] = '{1'b1, 10'd600,  1'b1, 1'b0, 10'h3FF};
        vecs[1] = '{1'b1, 10'd100,  1'b1, 1'b0, 10'h000};
        vecs[2] = '{1'b1, 10'd512,  1'b1, 1'b0, 10'h3FF};
        vecs[3] = '{1'b1, 10'd511,  1'b1, 1'b0, 10'h000};
        vecs[4] = '{1'b1, 10'd1023, 1'b0, 1'b0, 10'h3FF};
        vecs[5] = '{1'b0, 10'd0,    1'b1, 1'b0, 10'h000};
        vecs[6] = '{1'b0, 10'd700,  1'b0, 1'b0, 10'h3FF};
        vecs[7] = '{1'b1, 10'd0,    1'b1, 1'b1, 10'h000};

        do_reset();
        chk("rst_valid", 32'(out_if.valid), 32'd0);
        chk("rst_bin", 32'(out_if.data), 32'd0);
        chk("rst_done", 32'(out_if.done), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_count", 32'(result_count), 32'd0);
        chk("rst_min_x", 32'(result_min_x), 32'd0);

        // Pass-through table
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].v, vecs[i].g, vecs[i].vis, vecs[i].d);
            chk("tbl_valid", 32'(out_if.valid), 32'(vecs[i].v));
            chk("tbl_bin", 32'(out_if.data), 32'(vecs[i].eb));
            chk("tbl_visual", 32'(out_if.visual), 32'(vecs[i].vis));
            chk("tbl_done", 32'(out_if.done), 32'(vecs[i].d));
        end

        // Basic frame: fg at (2,1),(5,1),(3,3)
        do_reset();
        send_range(32'h0800_2400, 0, 31, 10'd600);
        done_pulse(2, 1'b0);
        check_res(3, 10, 5, 2, 5, 1, 3, 1'b0);

        // Mid-frame reset clears outputs and the partial frame
        send_range(32'hFFFF_FFFF, 0, 13, 10'd600);
        do_reset();
        chk("mrst_valid", 32'(out_if.valid), 32'd0);
        chk("mrst_bin", 32'(out_if.data), 32'd0);
        chk("mrst_done", 32'(out_if.done), 32'd0);
        chk("mrst_count", 32'(result_count), 32'd0);
        chk("mrst_sum_x", 32'(result_sum_x), 32'd0);
        chk("mrst_max_y", 32'(result_max_y), 32'd0);
        send_range(32'h0001_0000 << 4, 0, 31, 10'd600);
        done_pulse(1, 1'b0);
        check_res(1, 4, 2, 4, 4, 2, 2, 1'b0);

        // Empty frame
        send_range(32'h0, 0, 31, 10'd600);
        done_pulse(1, 1'b0);
        check_res(0, 0, 0, 0, 0, 0, 0, 1'b1);

        // Visual toggling: invisible fg pixels neither counted nor advance x
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 10'd600, 1'b0, 1'b0);
            chk("inv_bin", 32'(out_if.data), 32'h3FF);
            step(1'b1, (i == 1) ? 10'd600 : 10'd100, 1'b1, 1'b0);
        end
        done_pulse(1, 1'b0);
        check_res(1, 1, 0, 1, 1, 0, 0, 1'b0);

        // in_done held 5 cycles with pixels in the rise cycle and DONE_WAIT
        send_range(32'h8000_0000, 0, 31, 10'd600);
        done_pulse(5, 1'b1);
        check_res(1, 7, 3, 7, 7, 3, 3, 1'b0);
        send_range(32'h0000_0001, 0, 31, 10'd600);
        done_pulse(1, 1'b0);
        check_res(1, 0, 0, 0, 0, 0, 0, 1'b0);

        // Threshold change mid-frame takes effect only next frame
        send_range(32'h0800_0400, 0, 15, 10'd600);
        threshold = 10'd700;
        send_range(32'h0800_0400, 16, 31, 10'd600);
        done_pulse(1, 1'b0);
        check_res(2, 5, 4, 2, 3, 1, 3, 1'b0);
        thr_active = 10'd700;
        send_range(32'h0800_0400, 0, 31, 10'd600);
        done_pulse(1, 1'b0);
        check_res(0, 0, 0, 0, 0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
